// File: rtl/data_sram_bridge.sv
// data_sram_bridge: converts the CPU's single-cycle data SRAM port into a
// request/handshake memory interface with at most one outstanding access.
// The CPU pipeline is stalled while an access is in flight; read data is
// held in a register and is valid to the CPU once the access completes.
module data_sram_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_stall,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_complete;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wen;
    logic [31:0] r_rdata;

    // Next-state logic: accept in IDLE/DONE, handshake through REQ/WAIT
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (data_sram_en) begin
                    w_accept = 1'b1;
                    w_next   = S_REQ;
                end else begin
                    w_next   = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_addr_ok) begin
                    if (mem_data_ok) begin
                        w_complete = 1'b1;
                        w_next     = S_DONE;
                    end else begin
                        w_next     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_data_ok) begin
                    w_complete = 1'b1;
                    w_next     = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Capture the CPU request when it is accepted; held for the whole access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wen   <= '0;
        end else if (w_accept) begin
            r_addr  <= data_sram_addr;
            r_wdata <= data_sram_wdata;
            r_wen   <= data_sram_wen;
        end
    end

    // Read data register: loaded only when a read access completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_complete && (r_wen == 4'b0000)) begin
            r_rdata <= mem_rdata;
        end
    end

    assign data_stall      = (r_state == S_REQ) || (r_state == S_WAIT);
    assign mem_req         = (r_state == S_REQ);
    assign mem_wr          = (r_wen != 4'b0000);
    assign mem_wstrb       = r_wen;
    assign mem_addr        = r_addr;
    assign mem_wdata       = r_wdata;
    assign data_sram_rdata = r_rdata;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge: directed scenarios plus random
// accesses checked against a transaction-level expectation of stall length,
// request length, presented request fields and returned read data.
module tb_data_sram_bridge;

    logic        clk;
    logic        reset;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_stall;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_rdata = '0;

    data_sram_bridge dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .data_stall      (data_stall),
        .mem_req         (mem_req),
        .mem_wr          (mem_wr),
        .mem_wstrb       (mem_wstrb),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_addr_ok     (mem_addr_ok),
        .mem_data_ok     (mem_data_ok),
        .mem_rdata       (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Outputs expected whenever the bridge is not stalled (IDLE/DONE)
    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, 32'(data_stall), 32'd0);
        check({tag, "_req"},   32'(mem_req),    32'd0);
        check({tag, "_rdata"}, data_sram_rdata, exp_rdata);
    endtask

    task automatic idle_cycles(input int unsigned n);
        data_sram_en = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            check_quiet("idle");
        end
    endtask

    // One CPU access. Memory grants addr_ok a_dly cycles into REQ and
    // data_ok d_dly cycles after that (0 = same cycle). Expected: mem_req
    // high a_dly+1 cycles, stall a_dly+d_dly+1 cycles. CPU-side inputs are
    // scrambled while stalled, which the bridge must ignore.
    task automatic run_access(input logic [3:0] wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input int unsigned a_dly,
                              input int unsigned d_dly, input logic [31:0] mrd);
        int unsigned n_req;
        int unsigned n_stall;
        bit          done;
        data_sram_en    = 1'b1;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        @(posedge clk); #1;
        check("first_req", 32'(mem_req), 32'd1);
        n_req   = 0;
        n_stall = 0;
        done    = 1'b0;
        for (int unsigned k = 0; k < a_dly + d_dly + 8 && !done; k++) begin
            if (!data_stall) begin
                done = 1'b1;
            end else begin
                n_stall++;
                if (mem_req) n_req++;
                check("mem_addr",  mem_addr,          addr);
                check("mem_wdata", mem_wdata,         wdata);
                check("mem_wstrb", 32'(mem_wstrb),    32'(wen));
                check("mem_wr",    32'(mem_wr),       32'(wen != 4'b0000));
                check("rdata_hold", data_sram_rdata,  exp_rdata);
                mem_addr_ok     = (k == a_dly);
                mem_data_ok     = (k == a_dly + d_dly);
                mem_rdata       = (k == a_dly + d_dly) ? mrd : $urandom;
                data_sram_en    = 1'($urandom);
                data_sram_wen   = 4'($urandom);
                data_sram_addr  = $urandom;
                data_sram_wdata = $urandom;
                @(posedge clk); #1;
            end
        end
        mem_addr_ok  = 1'b0;
        mem_data_ok  = 1'b0;
        data_sram_en = 1'b0;
        check("no_timeout", 32'(done), 32'd1);
        if (wen == 4'b0000) exp_rdata = mrd;
        check("stall_cycles", n_stall, a_dly + d_dly + 1);
        check("req_cycles",   n_req,   a_dly + 1);
        check_quiet("done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        data_sram_en    = 1'b0;
        data_sram_wen   = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        mem_addr_ok     = 1'b0;
        mem_data_ok     = 1'b0;
        mem_rdata       = '0;
        #1;
        check("rst_stall", 32'(data_stall), 32'd0);
        check("rst_req",   32'(mem_req),    32'd0);
        check("rst_wr",    32'(mem_wr),     32'd0);
        check("rst_wstrb", 32'(mem_wstrb),  32'd0);
        check("rst_addr",  mem_addr,        32'd0);
        check("rst_wdata", mem_wdata,       32'd0);
        check("rst_rdata", data_sram_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle_cycles(1);

        // Scenario 1: read, zero wait states
        run_access(4'b0000, 32'h1FC0_0010, 32'h0, 0, 0, 32'hDEAD_BEEF);
        check("s1_rdata", data_sram_rdata, 32'hDEAD_BEEF);
        idle_cycles(1);

        // Scenario 2: write with wait states; read data must not change
        run_access(4'b0011, 32'h0000_1000, 32'h1234_5678, 3, 2, 32'hA5A5_A5A5);
        check("s2_rdata", data_sram_rdata, 32'hDEAD_BEEF);
        idle_cycles(1);

        // Scenario 3: back-to-back read then write accepted in DONE
        run_access(4'b0000, 32'h0000_2000, 32'h0, 1, 0, 32'h0BAD_F00D);
        run_access(4'b1111, 32'h0000_2004, 32'hCAFE_0001, 0, 1, 32'h1111_2222);
        check("s3_rdata", data_sram_rdata, 32'h0BAD_F00D);

        // Scenario 4: long WAIT with scrambled CPU inputs, then no extra request
        run_access(4'b0000, 32'h0000_3000, 32'h0, 0, 6, 32'h3333_4444);
        idle_cycles(2);

        // Scenario 6: spurious data_ok in IDLE and in DONE
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h5555_6666;
        @(posedge clk); #1;
        mem_data_ok = 1'b0;
        check_quiet("spur_idle");
        run_access(4'b0000, 32'h0000_3100, 32'h0, 0, 0, 32'h7777_8888);
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h9999_AAAA;
        @(posedge clk); #1;
        mem_data_ok = 1'b0;
        check_quiet("spur_done");
        idle_cycles(1);

        // Scenario 5: reset while in WAIT, stray data_ok after release
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'b0000;
        data_sram_addr = 32'h0000_4000;
        @(posedge clk); #1;
        data_sram_en = 1'b0;
        mem_addr_ok  = 1'b1;
        @(posedge clk); #1;
        mem_addr_ok = 1'b0;
        check("s5_wait_stall", 32'(data_stall), 32'd1);
        check("s5_wait_req",   32'(mem_req),    32'd0);
        #2 reset = 1'b1;
        #1;
        exp_rdata = '0;
        check("s5_stall", 32'(data_stall), 32'd0);
        check("s5_req",   32'(mem_req),    32'd0);
        check("s5_wr",    32'(mem_wr),     32'd0);
        check("s5_wstrb", 32'(mem_wstrb),  32'd0);
        check("s5_addr",  mem_addr,        32'd0);
        check("s5_wdata", mem_wdata,       32'd0);
        check("s5_rdata", data_sram_rdata, 32'd0);
        #2 reset = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_data_ok = 1'b0;
        check_quiet("s5_stray");

        // Access accepted on the very first edge after reset release
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        run_access(4'b0000, 32'h0000_5000, 32'h0, 0, 0, 32'h1357_9BDF);

        // Random accesses with random wait states and gaps
        for (int i = 0; i < 60; i++) begin
            logic [3:0] w;
            w = ($urandom_range(1, 0) == 0) ? 4'b0000 : 4'($urandom_range(15, 1));
            run_access(w, $urandom, $urandom, $urandom_range(4, 0),
                       $urandom_range(4, 0), $urandom);
            if ($urandom_range(2, 0) != 0) idle_cycles($urandom_range(2, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
